// File: rtl/bldc_pkg.sv
// -----------------------------------------------------------------------------
// bldc_pkg
// Shared definitions for the six-step BLDC commutator:
//   - phase drive request encoding (OFF / HIGH / LOW)
//   - phase identifiers A/B/C
//   - hall code -> sector table, sector -> (high phase, low phase) tables
//   - invalid hall codes and small helper functions
// -----------------------------------------------------------------------------
package bldc_pkg;

    typedef enum logic [1:0] {
        PH_OFF  = 2'b00,
        PH_HIGH = 2'b01,
        PH_LOW  = 2'b10
    } phase_t;

    localparam logic [1:0] PHASE_A = 2'd0;
    localparam logic [1:0] PHASE_B = 2'd1;
    localparam logic [1:0] PHASE_C = 2'd2;

    localparam logic [2:0] HALL_FAULT_LO = 3'b000;
    localparam logic [2:0] HALL_FAULT_HI = 3'b111;

    // Indexed by hall code {hall3,hall2,hall1}; fault codes map to 0 but are never used.
    localparam logic [2:0] HALL_TO_SECTOR [0:7] = '{
        3'd0, 3'd5, 3'd3, 3'd4, 3'd1, 3'd0, 3'd2, 3'd0
    };

    // Forward-direction roles per sector; entries 6 and 7 are unreachable padding.
    localparam logic [1:0] SECTOR_HIGH [0:7] = '{
        PHASE_A, PHASE_A, PHASE_B, PHASE_B, PHASE_C, PHASE_C, PHASE_A, PHASE_A
    };
    localparam logic [1:0] SECTOR_LOW [0:7] = '{
        PHASE_B, PHASE_C, PHASE_C, PHASE_A, PHASE_A, PHASE_B, PHASE_A, PHASE_A
    };

    function automatic logic is_hall_fault(input logic [2:0] code);
        return (code == HALL_FAULT_LO) || (code == HALL_FAULT_HI);
    endfunction

    // (new - old) mod 6 for sectors in 0..5
    function automatic logic [2:0] sector_delta(input logic [2:0] new_s, input logic [2:0] old_s);
        logic [3:0] w_sum;
        w_sum = {1'b0, new_s} + 4'd6 - {1'b0, old_s};
        if (w_sum >= 4'd6) begin
            w_sum = w_sum - 4'd6;
        end
        return w_sum[2:0];
    endfunction

    // Request for one phase; rev swaps the high/low roles within the sector.
    function automatic logic [1:0] phase_request(input logic [1:0] ph, input logic [1:0] hi,
                                                 input logic [1:0] lo, input logic rev,
                                                 input logic off);
        logic [1:0] w_req;
        w_req = PH_OFF;
        if (!off) begin
            if (ph == hi) begin
                w_req = rev ? PH_LOW : PH_HIGH;
            end else if (ph == lo) begin
                w_req = rev ? PH_HIGH : PH_LOW;
            end
        end
        return w_req;
    endfunction

endpackage

// File: rtl/bldc_commutator_deadtime.sv
// -----------------------------------------------------------------------------
// bldc_deadtime
// Per-phase gate driver with dead-time insertion.
//   CLK      : system clock
//   reset_n  : asynchronous active-low reset, gates off
//   request  : phase request (PH_OFF / PH_HIGH / PH_LOW)
//   pwm_in   : PWM applied to INH while the phase is HIGH
//   INH, INL : registered gate drives, never both 1
// Any request change forces both gates off for DEADTIME cycles before the new
// request is applied; a change to OFF is applied at once.
// -----------------------------------------------------------------------------
module bldc_deadtime
    import bldc_pkg::*;
#(
    parameter int DEADTIME = 16
) (
    input  logic       CLK,
    input  logic       reset_n,
    input  logic [1:0] request,
    input  logic       pwm_in,
    output logic       INH,
    output logic       INL
);

    localparam int                CNT_W   = $clog2(DEADTIME + 1);
    localparam logic [CNT_W-1:0]  DT_LOAD = CNT_W'(DEADTIME);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    logic [1:0]       r_req_prev;
    logic [1:0]       r_applied;
    logic [CNT_W-1:0] r_cnt;
    logic             r_inh;
    logic             r_inl;

    logic [1:0]       w_applied_next;
    logic [CNT_W-1:0] w_cnt_next;

    // A single applied state drives both gates, so INH and INL cannot overlap.
    always_comb begin
        w_applied_next = r_applied;
        w_cnt_next     = r_cnt;
        if (request != r_req_prev) begin
            w_applied_next = PH_OFF;
            w_cnt_next     = (request == PH_OFF) ? '0 : DT_LOAD;
        end else if (r_cnt != '0) begin
            w_cnt_next = r_cnt - CNT_ONE;
            if (r_cnt == CNT_ONE) begin
                w_applied_next = request;
            end
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_req_prev <= PH_OFF;
            r_applied  <= PH_OFF;
            r_cnt      <= '0;
            r_inh      <= 1'b0;
            r_inl      <= 1'b0;
        end else begin
            r_req_prev <= request;
            r_applied  <= w_applied_next;
            r_cnt      <= w_cnt_next;
            r_inh      <= (w_applied_next == PH_HIGH) & pwm_in;
            r_inl      <= (w_applied_next == PH_LOW);
        end
    end

    assign INH = r_inh;
    assign INL = r_inl;

endmodule

// File: rtl/bldc_commutator.sv
// -----------------------------------------------------------------------------
// bldc_commutator
// Six-step BLDC commutation: hall synchroniser + stability filter, sector
// decode, hall-step position, fault/skip/stall flags and dead-timed gates.
//   CLK, reset_n          : 32 MHz clock, asynchronous active-low reset
//   enable                : 1 = drive gates, 0 = all gates off
//   hall[2:0]             : raw asynchronous hall sensors {hall3,hall2,hall1}
//   pwm_in, dir           : PWM for the high side, 0 = forward / 1 = reverse
//   INHA..INLC            : registered active-high gate drives
//   hall_state, sector    : last accepted hall code and its sector 0..5
//   hall_fault, hall_skip : invalid code accepted / one-cycle sector-jump pulse
//   stalled               : no sector change for STALL_TIMEOUT cycles
//   position[23:0]        : signed hall-step count
// -----------------------------------------------------------------------------
module bldc_commutator
    import bldc_pkg::*;
#(
    parameter int DEADTIME      = 16,
    parameter int HALL_FILTER   = 4,
    parameter int STALL_TIMEOUT = 3_200_000
) (
    input  logic        CLK,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [2:0]  hall,
    input  logic        pwm_in,
    input  logic        dir,
    output logic        INHA,
    output logic        INLA,
    output logic        INHB,
    output logic        INLB,
    output logic        INHC,
    output logic        INLC,
    output logic [2:0]  hall_state,
    output logic [2:0]  sector,
    output logic        hall_fault,
    output logic        hall_skip,
    output logic        stalled,
    output logic [23:0] position
);

    localparam int               RUN_W   = $clog2(HALL_FILTER + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(HALL_FILTER);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
    localparam int               STL_W   = $clog2(STALL_TIMEOUT + 1);
    localparam logic [STL_W-1:0] STL_MAX = STL_W'(STALL_TIMEOUT);
    localparam logic [STL_W-1:0] STL_ONE = STL_W'(1);

    logic [2:0]        r_hall_sync_p0;
    logic [2:0]        r_hall_sync_p1;
    logic [2:0]        r_hall_prev;
    logic [RUN_W-1:0]  r_run;
    logic [2:0]        r_hall_state;
    logic [2:0]        r_sector;
    logic              r_hall_fault;
    logic              r_hall_skip;
    logic signed [23:0] r_position;
    logic [STL_W-1:0]  r_stall_cnt;

    logic [RUN_W-1:0]  w_run_next;
    logic              w_stable;
    logic [2:0]        w_cand;
    logic              w_cand_fault;
    logic [2:0]        w_new_sector;
    logic [2:0]        w_delta;
    logic              w_sector_change;
    logic              w_force_off;
    logic [1:0]        w_hi;
    logic [1:0]        w_lo;
    logic [1:0]        w_req_a;
    logic [1:0]        w_req_b;
    logic [1:0]        w_req_c;

    // ---- stage p0/p1: two-flop synchroniser on the asynchronous hall pins ----
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_hall_sync_p0 <= 3'b000;
            r_hall_sync_p1 <= 3'b000;
        end else begin
            r_hall_sync_p0 <= hall;
            r_hall_sync_p1 <= r_hall_sync_p0;
        end
    end

    // ---- filter: run length of identical synchronised samples, saturating ----
    assign w_cand     = r_hall_sync_p1;
    assign w_run_next = (w_cand != r_hall_prev) ? RUN_ONE :
                        (r_run == RUN_MAX)      ? r_run   : r_run + RUN_ONE;
    // Re-accepting the current code every stable cycle is harmless: delta is 0.
    assign w_stable   = (w_run_next == RUN_MAX);

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_hall_prev <= 3'b000;
            r_run       <= '0;
        end else begin
            r_hall_prev <= w_cand;
            r_run       <= w_run_next;
        end
    end

    // ---- decode: sector, position, fault/skip flags, stall counter ----
    assign w_cand_fault    = is_hall_fault(w_cand);
    assign w_new_sector    = HALL_TO_SECTOR[w_cand];
    assign w_delta         = sector_delta(w_new_sector, r_sector);
    assign w_sector_change = w_stable && !w_cand_fault && (w_new_sector != r_sector);

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_hall_state <= 3'b000;
            r_sector     <= 3'd0;
            r_hall_fault <= 1'b0;
            r_hall_skip  <= 1'b0;
            r_position   <= '0;
        end else begin
            r_hall_skip <= 1'b0;
            if (w_stable) begin
                r_hall_state <= w_cand;
                if (w_cand_fault) begin
                    r_hall_fault <= 1'b1;
                end else begin
                    r_hall_fault <= 1'b0;
                    r_sector     <= w_new_sector;
                    case (w_delta)
                        3'd1:             r_position <= r_position + 24'sd1;
                        3'd5:             r_position <= r_position - 24'sd1;
                        3'd2, 3'd3, 3'd4: r_hall_skip <= 1'b1;
                        default:          ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
        end else if (w_sector_change) begin
            r_stall_cnt <= '0;
        end else if (r_stall_cnt != STL_MAX) begin
            r_stall_cnt <= r_stall_cnt + STL_ONE;
        end
    end

    // ---- phase requests and dead-timed gate drivers ----
    // hall_state still holds its 000 reset value until the first code is
    // accepted, so the bridge also stays off before any valid hall reading.
    assign w_force_off = !enable || r_hall_fault || is_hall_fault(r_hall_state);
    assign w_hi        = SECTOR_HIGH[r_sector];
    assign w_lo        = SECTOR_LOW[r_sector];
    assign w_req_a     = phase_request(PHASE_A, w_hi, w_lo, dir, w_force_off);
    assign w_req_b     = phase_request(PHASE_B, w_hi, w_lo, dir, w_force_off);
    assign w_req_c     = phase_request(PHASE_C, w_hi, w_lo, dir, w_force_off);

    bldc_deadtime #(.DEADTIME(DEADTIME)) u_dt_a (
        .CLK(CLK), .reset_n(reset_n), .request(w_req_a), .pwm_in(pwm_in), .INH(INHA), .INL(INLA)
    );
    bldc_deadtime #(.DEADTIME(DEADTIME)) u_dt_b (
        .CLK(CLK), .reset_n(reset_n), .request(w_req_b), .pwm_in(pwm_in), .INH(INHB), .INL(INLB)
    );
    bldc_deadtime #(.DEADTIME(DEADTIME)) u_dt_c (
        .CLK(CLK), .reset_n(reset_n), .request(w_req_c), .pwm_in(pwm_in), .INH(INHC), .INL(INLC)
    );

    assign hall_state = r_hall_state;
    assign sector     = r_sector;
    assign hall_fault = r_hall_fault;
    assign hall_skip  = r_hall_skip;
    assign stalled    = (r_stall_cnt == STL_MAX);
    assign position   = r_position;

endmodule
